// File: rtl/ram_arb_rr2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_arb_rr2 : two-port single-cycle RAM arbiter, round-robin with locked  |
// |               bursts; define RAM_ARB_FIXED_PRIO_EN for fixed port-0 prio. |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
module ram_arb_rr2 #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_write,
  input  logic        p0_lock,
  input  logic [11:0] p0_address,
  input  logic [15:0] p0_writedata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [15:0] p0_readdata,
  input  logic        p1_req,
  input  logic        p1_write,
  input  logic        p1_lock,
  input  logic [11:0] p1_address,
  input  logic [15:0] p1_writedata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [15:0] p1_readdata,
  output logic [11:0] ram_address,
  output logic        ram_write,
  output logic        ram_read,
  output logic [15:0] ram_writedata,
  input  logic [15:0] ram_readdata
);

  logic       w_gnt0, w_gnt1, w_any, w_gp, w_pick, w_wr;
  logic [1:0] rvalid_q;

`ifdef RAM_ARB_FIXED_PRIO_EN
  logic w_unused;
  assign w_unused = p0_lock ^ p1_lock;
  assign w_pick   = 1'b0;
`else
  localparam logic [3:0] C_MAX = 4'(MAX_BURST);

  logic       prio_q, prio_d;
  logic       last_v_q, last_v_d;
  logic       last_p_q, last_p_d;
  logic       lock_q, lock_d;
  logic [3:0] cnt_q, cnt_d;
  logic       w_other;

  // Port picked when both request: forced hand-over, then locked owner, then pointer.
  always_comb begin
    if (cnt_q >= C_MAX) begin
      w_pick = ~last_p_q;
    end else if (lock_q) begin
      w_pick = last_p_q;
    end else begin
      w_pick = prio_q;
    end
  end

  assign w_other = w_gp ? p0_req : p1_req;

  always_comb begin
    prio_d   = prio_q;
    last_v_d = last_v_q;
    last_p_d = last_p_q;
    lock_d   = lock_q;
    cnt_d    = cnt_q;
    if (w_any) begin
      if (last_v_q && (last_p_q == w_gp)) begin
        if (w_other && (cnt_q < C_MAX)) begin
          cnt_d = cnt_q + 4'd1;
        end
      end else begin
        cnt_d = {3'b000, w_other};
      end
      last_v_d = 1'b1;
      last_p_d = w_gp;
      lock_d   = w_gp ? p1_lock : p0_lock;
      prio_d   = ~w_gp;
    end else begin
      last_v_d = 1'b0;
      lock_d   = 1'b0;
      cnt_d    = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q   <= 1'b0;
      last_v_q <= 1'b0;
      last_p_q <= 1'b0;
      lock_q   <= 1'b0;
      cnt_q    <= 4'd0;
    end else begin
      prio_q   <= prio_d;
      last_v_q <= last_v_d;
      last_p_q <= last_p_d;
      lock_q   <= lock_d;
      cnt_q    <= cnt_d;
    end
  end
`endif

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!reset) begin
      if (p0_req && p1_req) begin
        w_gnt0 = ~w_pick;
        w_gnt1 = w_pick;
      end else begin
        w_gnt0 = p0_req;
        w_gnt1 = p1_req;
      end
    end
  end

  assign w_any = w_gnt0 | w_gnt1;
  assign w_gp  = w_gnt1;
  assign w_wr  = w_gp ? p1_write : p0_write;

  assign p0_gnt        = w_gnt0;
  assign p1_gnt        = w_gnt1;
  assign ram_address   = w_gp ? p1_address : p0_address;
  assign ram_writedata = w_gp ? p1_writedata : p0_writedata;
  assign ram_write     = w_any & w_wr;
  assign ram_read      = w_any & ~w_wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q <= 2'b00;
    end else begin
      rvalid_q <= {w_gnt1, w_gnt0};
    end
  end

  // Masked so a grant issued just before reset never completes.
  assign p0_rvalid   = rvalid_q[0] & ~reset;
  assign p1_rvalid   = rvalid_q[1] & ~reset;
  assign p0_readdata = ram_readdata;
  assign p1_readdata = ram_readdata;

endmodule
`default_nettype wire

// File: doc/ram_arb_rr2.md
RAM_ARB_RR2 -- requirements
Module: ram_arb_rr2

Interface
REQ-001 Parameter: MAX_BURST, default 4, maximum consecutive grants to one port while the other port requests (range 1..15).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 pN_req  input  1  port N (N=0,1) request; held high until granted.
REQ-005 pN_write  input  1  port N write (1) / read (0) qualifier.
REQ-006 pN_lock  input  1  port N asks to keep ownership for the next transaction (burst).
REQ-007 pN_address  input  12  port N word address.
REQ-008 pN_writedata  input  16  port N write data.
REQ-009 pN_gnt  output  1  port N transaction issued to RAM this cycle.
REQ-010 pN_rvalid  output  1  port N transaction completed; readdata valid if it was a read.
REQ-011 pN_readdata  output  16  port N read data, driven from ram_readdata.
REQ-012 ram_address  output  12  RAM address.
REQ-013 ram_write  output  1  RAM write strobe.
REQ-014 ram_read  output  1  RAM read strobe.
REQ-015 ram_writedata  output  16  RAM write data.
REQ-016 ram_readdata  input  16  RAM read data, valid one cycle after the address.

Function
REQ-017 Each transaction SHALL be issued in one cycle: pN_gnt high combinationally, RAM signals driven from port N that same cycle.
REQ-018 At most one of p0_gnt/p1_gnt SHALL be high in any cycle; with no req both low and ram_write=ram_read=0.
REQ-019 pN_rvalid SHALL assert exactly one cycle after pN_gnt, for one cycle, regardless of read/write.
REQ-020 pN_readdata SHALL equal ram_readdata whenever pN_rvalid is high; value otherwise unspecified.
REQ-021 Issues SHALL be back-to-back capable: a new grant may occur in the same cycle as the previous rvalid.
REQ-022 Requester holding req high after gnt SHALL be treated as a new transaction (no duplicate suppression).
REQ-023 Single requester SHALL be granted immediately every cycle it requests.
REQ-024 Both requesting, no active burst: grant SHALL go to port indicated by priority pointer prio (reset 0); after that grant prio SHALL point to the other port.
REQ-025 Burst: if granted port had pN_lock=1 at its grant, it SHALL own next arbitration while pN_req stays high, until burst count reaches MAX_BURST.
REQ-026 Burst counter SHALL increment on each consecutive grant to the same port with the other port requesting, and clear on grant to the other port or cycle with no grant.
REQ-027 At count == MAX_BURST with other port requesting, ownership SHALL pass to the other port regardless of lock.
REQ-028 Owner dropping req mid-burst SHALL end the burst; arbitration reverts to REQ-024 that cycle.
REQ-029 ram_write SHALL equal granted pN_write; ram_read SHALL equal its inverse, both gated by a grant.

Reset
REQ-030 While reset is high: p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, ram_write, ram_read = 0; prio=0; burst counter=0; ownership cleared.
REQ-031 A transaction granted in the cycle before reset asserts SHALL NOT produce rvalid (reset wins).
REQ-032 First grant SHALL be possible in the first cycle after reset deasserts.

Configuration
REQ-033 Macro RAM_ARB_FIXED_PRIO_EN: when defined, port 0 SHALL always win simultaneous requests; prio, lock and burst logic removed, pN_lock ignored.
REQ-034 When RAM_ARB_FIXED_PRIO_EN is undefined, REQ-024..REQ-028 round-robin/burst behaviour SHALL apply.

Verification
REQ-035 p0 write addr 0x010 data 0xBEEF, then p1 read 0x010 -> p1_rvalid one cycle after p1_gnt with p1_readdata=0xBEEF.
REQ-036 Both req continuously, no lock, after reset -> grants 0,1,0,1...; each rvalid exactly one cycle after its gnt.
REQ-037 p1_lock=1, both req continuously, MAX_BURST=4 -> p1 granted 4 consecutive cycles after entering burst, then p0 granted.
REQ-038 p0 read granted, reset asserted next cycle -> p0_rvalid stays 0; after release first simultaneous request goes to p0.
REQ-039 With RAM_ARB_FIXED_PRIO_EN defined, both req continuously for 10 cycles -> p0_gnt high all 10 cycles, p1_gnt never.
